// File: rtl/hazard_forward_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : hazard_forward_ctrl_if
// Brief    : ID-stage decode fields in, stall and EX forwarding selects out.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface hazard_forward_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  flush;
    logic                  stall;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_rd, id_reg_write, id_mem_read, flush,
        input  stall, fwd_a_sel, fwd_b_sel
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_rd, id_reg_write, id_mem_read, flush,
        output stall, fwd_a_sel, fwd_b_sel
    );
endinterface

`default_nettype wire

// File: rtl/hazard_forward_ctrl.sv
//------------------------------------------------------------------------------
// Module   : hazard_forward_ctrl
// Brief    : RAW hazard tracker producing EX forwarding selects and load-use
//            stall. Define HAZ_FORWARD_EN to enable forwarding; otherwise every
//            RAW hazard stalls until the producer reaches WB.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_forward_ctrl #(
    parameter int REG_ADDR_W = 5
) (
    input  wire logic              clk,
    input  wire logic              reset,
    hazard_forward_ctrl_if.slave   bus
);

    localparam logic [1:0] c_SEL_RF    = 2'b00;
    localparam logic [1:0] c_SEL_EXMEM = 2'b10;
    localparam logic [1:0] c_SEL_MEMWB = 2'b01;

    // WB never forwards (write-before-read register file), so only EX and MEM are tracked
    logic                  r_ex_valid;
    logic [REG_ADDR_W-1:0] r_ex_rd;
    logic                  r_ex_reg_write;
    logic                  r_mem_valid;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic                  r_mem_reg_write;

    logic w_id_go;
    logic w_advance;
    logic w_ex_writer;
    logic w_mem_writer;
    logic w_rs_used;
    logic w_rt_used;
    logic w_rs_ex;
    logic w_rt_ex;
    logic w_rs_mem;
    logic w_rt_mem;

    assign w_id_go      = bus.id_valid & ~bus.flush;
    assign w_ex_writer  = r_ex_valid  & r_ex_reg_write  & (r_ex_rd  != '0);
    assign w_mem_writer = r_mem_valid & r_mem_reg_write & (r_mem_rd != '0);
    assign w_rs_used    = bus.id_uses_rs & (bus.id_rs != '0);
    assign w_rt_used    = bus.id_uses_rt & (bus.id_rt != '0);
    assign w_rs_ex      = w_rs_used & w_ex_writer  & (bus.id_rs == r_ex_rd);
    assign w_rt_ex      = w_rt_used & w_ex_writer  & (bus.id_rt == r_ex_rd);
    assign w_rs_mem     = w_rs_used & w_mem_writer & (bus.id_rs == r_mem_rd);
    assign w_rt_mem     = w_rt_used & w_mem_writer & (bus.id_rt == r_mem_rd);
    assign w_advance    = w_id_go & ~bus.stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid      <= 1'b0;
            r_ex_rd         <= '0;
            r_ex_reg_write  <= 1'b0;
            r_mem_valid     <= 1'b0;
            r_mem_rd        <= '0;
            r_mem_reg_write <= 1'b0;
        end else begin
            r_mem_valid     <= r_ex_valid;
            r_mem_rd        <= r_ex_rd;
            r_mem_reg_write <= r_ex_reg_write;
            r_ex_valid      <= w_advance;
            r_ex_rd         <= bus.id_rd;
            r_ex_reg_write  <= bus.id_reg_write;
        end
    end

`ifdef HAZ_FORWARD_EN
    logic       r_ex_mem_read;
    logic [1:0] r_fwd_a_sel;
    logic [1:0] r_fwd_b_sel;
    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;

    // Only a load in EX cannot be forwarded in time; everything else bypasses
    assign bus.stall = w_id_go & r_ex_mem_read & (w_rs_ex | w_rt_ex);

    assign w_sel_a = w_rs_ex ? c_SEL_EXMEM : (w_rs_mem ? c_SEL_MEMWB : c_SEL_RF);
    assign w_sel_b = w_rt_ex ? c_SEL_EXMEM : (w_rt_mem ? c_SEL_MEMWB : c_SEL_RF);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_mem_read <= 1'b0;
            r_fwd_a_sel   <= c_SEL_RF;
            r_fwd_b_sel   <= c_SEL_RF;
        end else begin
            r_ex_mem_read <= w_advance & bus.id_mem_read;
            r_fwd_a_sel   <= w_advance ? w_sel_a : c_SEL_RF;
            r_fwd_b_sel   <= w_advance ? w_sel_b : c_SEL_RF;
        end
    end

    assign bus.fwd_a_sel = r_fwd_a_sel;
    assign bus.fwd_b_sel = r_fwd_b_sel;
`else
    assign bus.stall     = w_id_go & (w_rs_ex | w_rt_ex | w_rs_mem | w_rt_mem);
    assign bus.fwd_a_sel = c_SEL_RF;
    assign bus.fwd_b_sel = c_SEL_RF;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_hazard_forward_ctrl
// Brief    : Scoreboard bench for hazard_forward_ctrl (honours HAZ_FORWARD_EN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_forward_ctrl;

`ifdef HAZ_FORWARD_EN
    localparam bit c_FWD_EN = 1'b1;
`else
    localparam bit c_FWD_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    hazard_forward_ctrl_if #(.REG_ADDR_W(5)) bus ();

    hazard_forward_ctrl #(.REG_ADDR_W(5)) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference pipeline model
    logic       m_ex_v, m_ex_rw, m_ex_mr, m_mem_v, m_mem_rw;
    logic [4:0] m_ex_rd, m_mem_rd;
    logic [3:0] sb_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_ex_v = 0; m_ex_rw = 0; m_ex_mr = 0; m_ex_rd = 0;
        m_mem_v = 0; m_mem_rw = 0; m_mem_rd = 0;
    endtask

    function automatic bit hits_ex(input logic used, input logic [4:0] src);
        return used && src != 0 && m_ex_v && m_ex_rw && m_ex_rd != 0 && src == m_ex_rd;
    endfunction

    function automatic bit hits_mem(input logic used, input logic [4:0] src);
        return used && src != 0 && m_mem_v && m_mem_rw && m_mem_rd != 0 && src == m_mem_rd;
    endfunction

    function automatic logic [1:0] exp_sel(input logic used, input logic [4:0] src);
        if (!c_FWD_EN)              return 2'b00;
        if (hits_ex(used, src))     return 2'b10;
        if (hits_mem(used, src))    return 2'b01;
        return 2'b00;
    endfunction

    // One ID cycle: drive, check stall, queue expected selects, clock, check selects
    task automatic step(input logic v, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic fl, output logic stalled);
        logic go, st, adv;
        logic [3:0] exp, got;
        bus.id_valid = v;  bus.id_rs = rs; bus.id_uses_rs = urs;
        bus.id_rt = rt;    bus.id_uses_rt = urt; bus.id_rd = rd;
        bus.id_reg_write = rw; bus.id_mem_read = mr; bus.flush = fl;
        #1;
        go = v && !fl;
        if (c_FWD_EN)
            st = go && m_ex_mr && (hits_ex(urs, rs) || hits_ex(urt, rt));
        else
            st = go && (hits_ex(urs, rs) || hits_ex(urt, rt) || hits_mem(urs, rs) || hits_mem(urt, rt));
        check_eq("stall", {31'd0, bus.stall}, {31'd0, st});
        adv = go && !st;
        sb_q.push_back(adv ? {exp_sel(urs, rs), exp_sel(urt, rt)} : 4'b0000);
        m_mem_v = m_ex_v; m_mem_rw = m_ex_rw; m_mem_rd = m_ex_rd;
        m_ex_v = adv; m_ex_rw = rw; m_ex_mr = adv && mr; m_ex_rd = rd;
        stalled = st;
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        got = {bus.fwd_a_sel, bus.fwd_b_sel};
        check_eq("fwd_a_sel", {30'd0, got[3:2]}, {30'd0, exp[3:2]});
        check_eq("fwd_b_sel", {30'd0, got[1:0]}, {30'd0, exp[1:0]});
    endtask

    // Re-present an instruction while the model says it is stalled
    task automatic issue(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                         input logic urt, input logic [4:0] rd, input logic rw, input logic mr);
        logic st;
        int   n;
        n = 0;
        do begin
            step(1'b1, rs, urs, rt, urt, rd, rw, mr, 1'b0, st);
            n++;
        end while (st && n < 4);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        issue(rs, 1'b1, rt, 1'b1, rd, 1'b1, 1'b0);
    endtask

    task automatic lw(input logic [4:0] rd, input logic [4:0] base);
        issue(base, 1'b1, 5'd0, 1'b0, rd, 1'b1, 1'b1);
    endtask

    task automatic nops(input int n);
        logic st;
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, st);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.id_valid = 1'($urandom); bus.id_rs = 5'($urandom); bus.id_rt = 5'($urandom);
            bus.id_uses_rs = 1'($urandom); bus.id_uses_rt = 1'($urandom);
            bus.id_rd = 5'($urandom); bus.id_reg_write = 1'($urandom);
            bus.id_mem_read = 1'($urandom); bus.flush = 1'($urandom);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        model_clear();
        sb_q.delete();
        #1;
        check_eq("rst_stall", {31'd0, bus.stall}, 32'd0);
        check_eq("rst_fwd_a", {30'd0, bus.fwd_a_sel}, 32'd0);
        check_eq("rst_fwd_b", {30'd0, bus.fwd_b_sel}, 32'd0);
    endtask

    initial begin
        logic st;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // ALU -> ALU
        alu(5'd3, 5'd1, 5'd2);
        alu(5'd5, 5'd3, 5'd4);
        nops(3);
        // Two producers of r3: newest wins; then distance two via MEM
        alu(5'd3, 5'd1, 5'd2);
        alu(5'd3, 5'd1, 5'd1);
        alu(5'd6, 5'd3, 5'd3);
        nops(3);
        alu(5'd3, 5'd1, 5'd2);
        alu(5'd9, 5'd1, 5'd2);
        alu(5'd6, 5'd3, 5'd3);
        nops(3);
        // Load-use
        lw(5'd2, 5'd1);
        alu(5'd7, 5'd2, 5'd1);
        nops(3);
        // Register zero
        alu(5'd0, 5'd1, 5'd2);
        alu(5'd8, 5'd0, 5'd0);
        nops(3);
        // Flush beats load-use stall
        lw(5'd2, 5'd1);
        step(1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, st);
        nops(3);
        // Reset while a load-use stall is pending
        lw(5'd2, 5'd1);
        step(1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, st);
        do_reset();
        step(1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, st);
        nops(3);

        // Random traffic over a small register set to provoke hazards
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 1'($urandom),
                 5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0), st);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Pipeline hazard controller for the MIPS-DLX core: tracks destination registers of in-flight instructions (EX, MEM, WB) and produces the 2-bit operand-select codes that drive the EX-stage 3:1 forwarding muxes, plus a load-use stall request. Sits beside the ID/EX pipeline register and consumes decoded ID-stage fields each cycle. Its select codes use the forwarding-mux encoding: 00 register file, 10 EX/MEM result, 01 MEM/WB result; 11 is never driven.

## Interface
Parameters:
- REG_ADDR_W, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_ADDR_W  ID source registers.
- id_uses_rs, id_uses_rt  in  1  source actually read.
- id_rd  in  REG_ADDR_W  ID destination register.
- id_reg_write  in  1  instruction writes id_rd.
- id_mem_read  in  1  instruction is a load.
- flush  in  1  squash ID instruction (taken branch/jump).
- stall  out  1  combinational; hold PC and IF/ID, bubble into EX.
- fwd_a_sel, fwd_b_sel  out  2  registered selects for EX operands A (rs) and B (rt).

## Operation
- Internal tracking slots ex_*, mem_*, wb_*, each {valid, rd, reg_write, mem_read}; a slot is a "writer" when valid & reg_write & rd != 0.
- Every cycle: wb <= mem, mem <= ex. ex <= ID fields when id_valid & !flush & !stall; otherwise ex <= bubble (valid=0).
- Load-use stall: stall = id_valid & !flush & ex writer & ex_mem_read & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- Select computation (per source, evaluated on ID fields, registered when ID advances into EX):
  - source unused or register 0 -> 00.
  - matches ex writer (non-load, else stall) -> 10 (result will be in EX/MEM).
  - else matches mem writer -> 01 (result will be in MEM/WB).
  - else -> 00.
  - EX/MEM match takes priority over MEM/WB (most recent producer wins).
- When a bubble enters EX (stall, flush, !id_valid): fwd_a_sel, fwd_b_sel <= 00.
- WB-stage writers never forward; register file is write-before-read.

## Timing
- Reset: all slots invalid, fwd_a_sel = fwd_b_sel = 00, stall = 0 (no valid ex slot).
- stall: zero latency, same cycle as the ID inputs; held while the load remains in EX, i.e. exactly one cycle per load-use hazard.
- Selects: one-cycle latency, valid throughout the instruction's EX cycle.
- flush and stall in the same cycle: flush wins, stall = 0, bubble inserted.
- reset mid-stall: next cycle stall = 0, all in-flight state discarded.
- Back-to-back hazards: a stalled instruction re-evaluates next cycle against updated slots (load now in MEM -> select 01).

## Configuration
- HAZ_FORWARD_EN defined: forwarding as above.
- HAZ_FORWARD_EN undefined: fwd_a_sel/fwd_b_sel tied to 00; stall asserted whenever a used, nonzero ID source matches any ex or mem writer (load or not), so every RAW hazard resolves by stalling until the producer reaches WB.

## Test plan
- Reset: assert reset 2 cycles with arbitrary inputs -> stall=0, both sels 00 the cycle after release.
- ALU->ALU: add r3 then sub r5,r3,r4 back-to-back -> sub's EX cycle fwd_a_sel=10, fwd_b_sel=00, no stall.
- Distance 2 and priority: add r3; add r3(second); or r6,r3,r3 -> sels 10/10 (newest); with unrelated middle instruction -> 01/01.
- Load-use: lw r2; add r7,r2,r1 -> stall=1 exactly one cycle, EX bubble with sels 00, then add in EX with fwd_a_sel=01.
- Register 0 and flush: writer to r0 followed by reader of r0 -> sels 00, no stall; lw r2 + dependent add with flush=1 -> stall=0, bubble.
- Macro off: ALU->ALU dependency -> stall for 2 cycles, sels stay 00.
